// File: rtl/billiard_pkg.sv
// Shared types and defaults for the billiard ball-motion blocks.
package billiard_pkg;

    localparam int DEF_NUM_BALLS = 3;
    localparam int DEF_SPEED_W   = 11;

    typedef enum logic [1:0] {
        NONE   = 2'b00,
        VERT   = 2'b01,
        HORZ   = 2'b10,
        CORNER = 2'b11
    } wall_code_t;

    typedef enum logic [2:0] {
        IDLE,
        WALL,
        PAIR,
        FRIC,
        DONE
    } resp_state_t;

    typedef logic signed [DEF_SPEED_W-1:0] speed_t;

endpackage

// File: rtl/collision_responder_if.sv
// Collision reports in, per-ball speeds and sequencing status out.
interface collision_responder_if
    import billiard_pkg::*;
#(
    parameter int NUM_BALLS = DEF_NUM_BALLS,
    parameter int SPEED_W   = DEF_SPEED_W
);
    logic                                startOfFrame;
    logic [NUM_BALLS-1:0]                ballwall_collide;
    logic [1:0]                          collided_wall;
    logic [NUM_BALLS-1:0]                balls_collide;
    logic [1:0][3:0]                     Balls_col_ID;
    logic [NUM_BALLS-1:0]                balls_in_game;
    logic                                shot_valid;
    logic signed [SPEED_W-1:0]           shot_x_speed;
    logic signed [SPEED_W-1:0]           shot_y_speed;
    logic                                shot_ready;
    logic [NUM_BALLS-1:0][SPEED_W-1:0]   ball_x_speed;
    logic [NUM_BALLS-1:0][SPEED_W-1:0]   ball_y_speed;
    logic                                busy;
    logic                                update_done;

    modport master (
        output startOfFrame, ballwall_collide, collided_wall, balls_collide,
               Balls_col_ID, balls_in_game, shot_valid, shot_x_speed, shot_y_speed,
        input  shot_ready, ball_x_speed, ball_y_speed, busy, update_done
    );

    modport slave (
        input  startOfFrame, ballwall_collide, collided_wall, balls_collide,
               Balls_col_ID, balls_in_game, shot_valid, shot_x_speed, shot_y_speed,
        output shot_ready, ball_x_speed, ball_y_speed, busy, update_done
    );

endinterface

// File: rtl/collision_responder_speed_step.sv
// Single speed component: saturating negate, or one step toward zero.
module speed_step
    import billiard_pkg::*;
#(
    parameter int W = $bits(speed_t)
) (
    input  logic signed [W-1:0] val_in,
    input  logic                negate,
    input  logic                toward_zero,
    output logic signed [W-1:0] val_out
);
    localparam logic signed [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};
    localparam logic signed [W-1:0] MAX_VAL = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] ONE     = {{(W-1){1'b0}}, 1'b1};

    always_comb begin
        val_out = val_in;
        if (negate) begin
            val_out = (val_in == MIN_VAL) ? MAX_VAL : -val_in;
        end else if (toward_zero && (val_in != '0)) begin
            val_out = val_in[W-1] ? (val_in + ONE) : (val_in - ONE);
        end
    end

endmodule

// File: rtl/collision_responder.sv
// Latches per-frame collision events and, at each frame start, applies
// wall reflection, ball-ball swap, pocketing and friction to the ball speeds.
module collision_responder
    import billiard_pkg::*;
#(
    parameter int NUM_BALLS    = DEF_NUM_BALLS,
    parameter int SPEED_W      = DEF_SPEED_W,
    parameter int FRICTION_DIV = 4
) (
    input  logic                  clk,
    input  logic                  resetN,
    collision_responder_if.slave  bus
);
    localparam int               IDX_W     = (NUM_BALLS > 1) ? $clog2(NUM_BALLS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_BALLS - 1);
    localparam logic [3:0]       NB_ID     = 4'(NUM_BALLS);
    localparam logic [3:0]       FRIC_LAST = 4'(FRICTION_DIV - 1);

    typedef logic signed [SPEED_W-1:0] spd_t;

    resp_state_t          state_q, state_d;
    logic [NUM_BALLS-1:0] pend_x_q, pend_x_d, pend_y_q, pend_y_d;
    logic [NUM_BALLS-1:0] wall_x_q, wall_x_d, wall_y_q, wall_y_d;
    logic [1:0][3:0]      pair_pend_q, pair_pend_d, pair_q, pair_d;
    logic [3:0]           frame_cnt_q, frame_cnt_d;
    logic                 fric_frame_q, fric_frame_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    spd_t                 spd_x_q [NUM_BALLS];
    spd_t                 spd_x_d [NUM_BALLS];
    spd_t                 spd_y_q [NUM_BALLS];
    spd_t                 spd_y_d [NUM_BALLS];
    spd_t                 step_x  [NUM_BALLS];
    spd_t                 step_y  [NUM_BALLS];
    logic [NUM_BALLS-1:0] do_negx, do_negy, do_dec;
    logic                 snapshot, hit_x, hit_y, pair_ok;
    logic [IDX_W-1:0]     id_a, id_b;
    wall_code_t           wall_code;

    assign snapshot  = (state_q == IDLE) && bus.startOfFrame;
    assign wall_code = wall_code_t'(bus.collided_wall);
    assign hit_x     = (wall_code == VERT) || (wall_code == CORNER);
    assign hit_y     = (wall_code == HORZ) || (wall_code == CORNER);
    assign pair_ok   = (pair_q[0] != pair_q[1]) && (pair_q[0] < NB_ID) && (pair_q[1] < NB_ID);
    assign id_a      = pair_q[0][IDX_W-1:0];
    assign id_b      = pair_q[1][IDX_W-1:0];

    // One step unit per component: negation in WALL, decrement only for the FRIC ball.
    for (genvar gi = 0; gi < NUM_BALLS; gi++) begin : g_ball
        assign do_negx[gi] = (state_q == WALL) && wall_x_q[gi];
        assign do_negy[gi] = (state_q == WALL) && wall_y_q[gi];
        assign do_dec[gi]  = (state_q == FRIC) && fric_frame_q && (idx_q == IDX_W'(gi));

        speed_step #(.W(SPEED_W)) u_step_x (
            .val_in(spd_x_q[gi]), .negate(do_negx[gi]),
            .toward_zero(do_dec[gi]), .val_out(step_x[gi])
        );
        speed_step #(.W(SPEED_W)) u_step_y (
            .val_in(spd_y_q[gi]), .negate(do_negy[gi]),
            .toward_zero(do_dec[gi]), .val_out(step_y[gi])
        );

        assign bus.ball_x_speed[gi] = spd_x_q[gi];
        assign bus.ball_y_speed[gi] = spd_y_q[gi];
    end

    always_ff @(posedge clk) begin
        if (!resetN) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.startOfFrame) state_d = WALL;
            WALL:    state_d = PAIR;
            PAIR:    state_d = FRIC;
            FRIC:    if (idx_q == LAST_IDX) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.busy        = (state_q != IDLE);
        bus.update_done = (state_q == DONE);
        bus.shot_ready  = (state_q == IDLE);
    end

    // Events arriving in the snapshot cycle land in the freshly cleared pending set.
    always_comb begin
        pend_x_d     = (snapshot ? '0 : pend_x_q) | (bus.ballwall_collide & {NUM_BALLS{hit_x}});
        pend_y_d     = (snapshot ? '0 : pend_y_q) | (bus.ballwall_collide & {NUM_BALLS{hit_y}});
        pair_pend_d  = snapshot ? '0 : pair_pend_q;
        if (|bus.balls_collide) pair_pend_d = bus.Balls_col_ID;
        wall_x_d     = wall_x_q;
        wall_y_d     = wall_y_q;
        pair_d       = pair_q;
        frame_cnt_d  = frame_cnt_q;
        fric_frame_d = fric_frame_q;
        if (snapshot) begin
            wall_x_d     = pend_x_q;
            wall_y_d     = pend_y_q;
            pair_d       = pair_pend_q;
            fric_frame_d = (frame_cnt_q == 4'd0);
            frame_cnt_d  = (frame_cnt_q >= FRIC_LAST) ? 4'd0 : frame_cnt_q + 4'd1;
        end
        idx_d = (state_q == FRIC) ? idx_q + 1'b1 : '0;
    end

    always_comb begin
        for (int i = 0; i < NUM_BALLS; i++) begin
            spd_x_d[i] = spd_x_q[i];
            spd_y_d[i] = spd_y_q[i];
        end
        case (state_q)
            IDLE: begin
                if (bus.shot_valid) begin
                    spd_x_d[0] = bus.shot_x_speed;
                    spd_y_d[0] = bus.shot_y_speed;
                end
            end
            WALL: begin
                for (int i = 0; i < NUM_BALLS; i++) begin
                    spd_x_d[i] = step_x[i];
                    spd_y_d[i] = step_y[i];
                end
            end
            PAIR: begin
                if (pair_ok) begin
                    spd_x_d[id_a] = spd_x_q[id_b];
                    spd_y_d[id_a] = spd_y_q[id_b];
                    spd_x_d[id_b] = spd_x_q[id_a];
                    spd_y_d[id_b] = spd_y_q[id_a];
                end
            end
            FRIC: begin
                for (int i = 0; i < NUM_BALLS; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        spd_x_d[i] = bus.balls_in_game[i] ? step_x[i] : '0;
                        spd_y_d[i] = bus.balls_in_game[i] ? step_y[i] : '0;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            pend_x_q     <= '0;
            pend_y_q     <= '0;
            wall_x_q     <= '0;
            wall_y_q     <= '0;
            pair_pend_q  <= '0;
            pair_q       <= '0;
            frame_cnt_q  <= '0;
            fric_frame_q <= 1'b0;
            idx_q        <= '0;
            for (int i = 0; i < NUM_BALLS; i++) begin
                spd_x_q[i] <= '0;
                spd_y_q[i] <= '0;
            end
        end else begin
            pend_x_q     <= pend_x_d;
            pend_y_q     <= pend_y_d;
            wall_x_q     <= wall_x_d;
            wall_y_q     <= wall_y_d;
            pair_pend_q  <= pair_pend_d;
            pair_q       <= pair_d;
            frame_cnt_q  <= frame_cnt_d;
            fric_frame_q <= fric_frame_d;
            idx_q        <= idx_d;
            for (int i = 0; i < NUM_BALLS; i++) begin
                spd_x_q[i] <= spd_x_d[i];
                spd_y_q[i] <= spd_y_d[i];
            end
        end
    end

endmodule

// File: tb/tb_collision_responder.sv
// Directed bench: frame-level model checked every cycle, plus literal speed pins.
module tb_collision_responder;
    localparam int NB   = 3;
    localparam int SW   = 11;
    localparam int FD   = 4;
    localparam int SMIN = -(1 << (SW - 1));
    localparam int SMAX = (1 << (SW - 1)) - 1;

    logic clk = 1'b0;
    logic resetN;

    collision_responder_if #(.NUM_BALLS(NB), .SPEED_W(SW)) bus ();

    collision_responder #(.NUM_BALLS(NB), .SPEED_W(SW), .FRICTION_DIV(FD)) dut (
        .clk(clk), .resetN(resetN), .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int m_x [NB];
    int m_y [NB];
    bit m_px [NB];
    bit m_py [NB];
    int m_pa, m_pb, m_fcnt, m_cnt;

    function automatic int sat_neg(int v);
        return (v == SMIN) ? SMAX : -v;
    endfunction

    function automatic int toward0(int v);
        if (v > 0) return v - 1;
        if (v < 0) return v + 1;
        return 0;
    endfunction

    task automatic chk(string name, logic signed [31:0] act, logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NB; i++) begin
            m_x[i] = 0; m_y[i] = 0; m_px[i] = 0; m_py[i] = 0;
        end
        m_pa = 0; m_pb = 0; m_fcnt = 0; m_cnt = 0;
    endtask

    // Whole-frame effect of the pending events on the speed table.
    task automatic model_frame();
        bit fric;
        int t;
        fric   = (m_fcnt == 0);
        m_fcnt = (m_fcnt + 1) % FD;
        for (int i = 0; i < NB; i++) begin
            if (m_px[i]) m_x[i] = sat_neg(m_x[i]);
            if (m_py[i]) m_y[i] = sat_neg(m_y[i]);
        end
        if (m_pa != m_pb && m_pa < NB && m_pb < NB) begin
            t = m_x[m_pa]; m_x[m_pa] = m_x[m_pb]; m_x[m_pb] = t;
            t = m_y[m_pa]; m_y[m_pa] = m_y[m_pb]; m_y[m_pb] = t;
        end
        for (int i = 0; i < NB; i++) begin
            if (!bus.balls_in_game[i]) begin
                m_x[i] = 0; m_y[i] = 0;
            end else if (fric) begin
                m_x[i] = toward0(m_x[i]); m_y[i] = toward0(m_y[i]);
            end
            m_px[i] = 0; m_py[i] = 0;
        end
        m_pa = 0; m_pb = 0;
    endtask

    initial begin
        model_clear();
        forever begin
            @(posedge clk);
            if (!resetN) begin
                model_clear();
            end else begin
                if (m_cnt == 0) begin
                    if (bus.shot_valid) begin
                        m_x[0] = int'(bus.shot_x_speed);
                        m_y[0] = int'(bus.shot_y_speed);
                    end
                    if (bus.startOfFrame) begin
                        model_frame();
                        m_cnt = NB + 3;
                    end
                end else begin
                    m_cnt--;
                end
                for (int i = 0; i < NB; i++) begin
                    if (bus.ballwall_collide[i]) begin
                        if (bus.collided_wall[0]) m_px[i] = 1;
                        if (bus.collided_wall[1]) m_py[i] = 1;
                    end
                end
                if (bus.balls_collide != '0) begin
                    m_pa = int'(bus.Balls_col_ID[0]);
                    m_pb = int'(bus.Balls_col_ID[1]);
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("busy", 32'(bus.busy), (m_cnt > 0) ? 1 : 0);
            chk("update_done", 32'(bus.update_done), (m_cnt == 1) ? 1 : 0);
            chk("shot_ready", 32'(bus.shot_ready), (m_cnt == 0) ? 1 : 0);
            if (m_cnt <= 1) begin
                for (int i = 0; i < NB; i++) begin
                    chk($sformatf("model_b%0d_x", i), 32'($signed(bus.ball_x_speed[i])), m_x[i]);
                    chk($sformatf("model_b%0d_y", i), 32'($signed(bus.ball_y_speed[i])), m_y[i]);
                end
            end
        end
    end

    task automatic lit(string name, int ball, int x, int y);
        chk({name, "_x"}, 32'($signed(bus.ball_x_speed[ball])), x);
        chk({name, "_y"}, 32'($signed(bus.ball_y_speed[ball])), y);
        $display("lit %s ball%0d: (%0d,%0d) expected (%0d,%0d)", name, ball,
                 $signed(bus.ball_x_speed[ball]), $signed(bus.ball_y_speed[ball]), x, y);
    endtask

    task automatic shot(int x, int y);
        @(negedge clk);
        bus.shot_valid = 1'b1; bus.shot_x_speed = SW'(x); bus.shot_y_speed = SW'(y);
        @(negedge clk);
        bus.shot_valid = 1'b0;
    endtask

    task automatic wall(logic [NB-1:0] mask, logic [1:0] code);
        @(negedge clk);
        bus.ballwall_collide = mask; bus.collided_wall = code;
        @(negedge clk);
        bus.ballwall_collide = '0; bus.collided_wall = 2'b00;
    endtask

    task automatic pair(int a, int b);
        @(negedge clk);
        bus.balls_collide = 3'b001; bus.Balls_col_ID[0] = 4'(a); bus.Balls_col_ID[1] = 4'(b);
        @(negedge clk);
        bus.balls_collide = '0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (bus.busy && k < 40) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (bus.busy) begin
            errors++;
            $display("FAIL idle_timeout: busy=%0d after %0d cycles, required 0", bus.busy, k);
        end
    endtask

    task automatic frame();
        @(negedge clk);
        bus.startOfFrame = 1'b1;
        @(negedge clk);
        bus.startOfFrame = 1'b0;
        wait_idle();
    endtask

    initial begin
        resetN = 1'b0;
        bus.startOfFrame = 1'b0; bus.ballwall_collide = '0; bus.collided_wall = 2'b00;
        bus.balls_collide = '0; bus.Balls_col_ID = '0; bus.balls_in_game = 3'b111;
        bus.shot_valid = 1'b0; bus.shot_x_speed = '0; bus.shot_y_speed = '0;
        repeat (3) @(negedge clk);
        resetN = 1'b1;
        lit("reset", 0, 0, 0);

        // Frame 1 (friction): move shot onto ball 1 via a swap.
        shot(6, -4); pair(0, 1); frame();
        lit("setup_b1", 1, 5, -3);
        lit("setup_b0", 0, 0, 0);

        wall(3'b010, 2'b01); frame();
        lit("wall_vert", 1, -5, -3);

        shot(-2, 1); pair(0, 2); frame();
        shot(4, 0); pair(0, 2); frame();
        lit("swap_b0", 0, -2, 1);
        lit("swap_b2", 2, 4, 0);

        pair(1, 1); frame();
        lit("same_id_b1", 1, -4, -2);
        lit("same_id_b0", 0, -1, 0);

        shot(7, 7); pair(0, 1); frame();
        lit("load_b1", 1, 7, 7);
        @(negedge clk); bus.balls_in_game = 3'b101;
        frame();
        lit("pocket_b1", 1, 0, 0);
        lit("pocket_b2", 2, 3, 0);
        @(negedge clk); bus.balls_in_game = 3'b111;

        // Fresh frame counter for the friction cadence.
        @(negedge clk); resetN = 1'b0;
        @(negedge clk); resetN = 1'b1;
        shot(3, -3);
        frame(); lit("fric_f1", 0, 2, -2);
        frame(); lit("fric_f2", 0, 2, -2);
        frame(); lit("fric_f3", 0, 2, -2);
        frame(); lit("fric_f4", 0, 2, -2);
        frame(); lit("fric_f5", 0, 1, -1);

        // Wall event in the snapshot cycle, plus a frame pulse while busy.
        @(negedge clk);
        bus.startOfFrame = 1'b1; bus.ballwall_collide = 3'b001; bus.collided_wall = 2'b01;
        @(negedge clk);
        bus.startOfFrame = 1'b0; bus.ballwall_collide = '0; bus.collided_wall = 2'b00;
        @(negedge clk); bus.startOfFrame = 1'b1;
        @(negedge clk); bus.startOfFrame = 1'b0;
        wait_idle();
        lit("snap_defer", 0, 1, -1);
        frame(); lit("snap_apply", 0, -1, -1);
        frame(); lit("ignored_f8", 0, -1, -1);
        frame(); lit("ignored_f9", 0, 0, 0);

        shot(SMIN, 5); wall(3'b001, 2'b01); frame();
        lit("sat_neg", 0, SMAX, 5);

        shot(10, -6);
        lit("shot_load", 0, 10, -6);

        // Shot presented only while busy must be dropped.
        @(negedge clk); bus.startOfFrame = 1'b1;
        @(negedge clk);
        bus.startOfFrame = 1'b0; bus.shot_valid = 1'b1;
        bus.shot_x_speed = SW'(99); bus.shot_y_speed = SW'(99);
        @(negedge clk);
        @(negedge clk); bus.shot_valid = 1'b0;
        wait_idle();
        lit("shot_busy", 0, 10, -6);

        // Reset during FRIC with a wall event pending from inside the sequence.
        @(negedge clk); bus.startOfFrame = 1'b1;
        @(negedge clk);
        bus.startOfFrame = 1'b0; bus.ballwall_collide = 3'b001; bus.collided_wall = 2'b01;
        @(negedge clk); bus.ballwall_collide = '0; bus.collided_wall = 2'b00;
        @(negedge clk); resetN = 1'b0;
        @(negedge clk); resetN = 1'b1;
        chk("rst_busy", 32'(bus.busy), 0);
        lit("rst_b0", 0, 0, 0);
        lit("rst_b2", 2, 0, 0);
        shot(8, 8); frame();
        lit("rst_pend_cleared", 0, 7, 7);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/collision_responder.md
# collision_responder

Consumes the per-frame collision reports from the game controller and turns them into per-ball velocity updates for the ball movement blocks. Events are latched as they arrive during a frame. At each `startOfFrame` a short state machine applies, in order: wall reflection, ball-ball velocity swap, pocketing (zeroing) and periodic friction. It then publishes the new speeds with a one-cycle done pulse.

## Interface
Parameters:
- `NUM_BALLS`, 3: number of balls; index 0 is the cue (white) ball.
- `SPEED_W`, 11: signed speed width in pixels per frame, two's complement.
- `FRICTION_DIV`, 4: friction is applied once every `FRICTION_DIV` frames; legal range 1..15.

Ports:
- `clk` in 1: system clock.
- `resetN` in 1: synchronous, active-low reset.
- `startOfFrame` in 1: single-cycle pulse at the start of each frame.
- `ballwall_collide` in NUM_BALLS: one-cycle pulse, one bit per ball that touched a wall.
- `collided_wall` in 2: valid with `ballwall_collide`. Codes: 01 = vertical wall (negate X), 10 = horizontal wall (negate Y), 11 = corner (negate both), 00 = ignore.
- `balls_collide` in NUM_BALLS: one-cycle pulse marking a ball-ball contact.
- `Balls_col_ID` in 2x4: IDs of the two contacting balls; valid when `balls_collide != 0`.
- `balls_in_game` in NUM_BALLS: level signal; a bit is 0 once that ball is pocketed.
- `shot_valid` in 1: cue strike request.
- `shot_x_speed`, `shot_y_speed` in SPEED_W signed: cue ball speed to load.
- `shot_ready` out 1: equals `!busy`.
- `ball_x_speed`, `ball_y_speed` out NUM_BALLS x SPEED_W signed: current speed of each ball.
- `busy` out 1: high while the state machine is outside IDLE.
- `update_done` out 1: one-cycle pulse when an update sequence finishes.

## Operation
- Reset values: all speeds 0, `busy` 0, `update_done` 0, pending registers 0, frame counter 0, state IDLE.
- Capture, active in every state:
  - `wall_pend_x[i]` is set when `ballwall_collide[i]` is high and `collided_wall[0]` is high.
  - `wall_pend_y[i]` is set when `ballwall_collide[i]` is high and `collided_wall[1]` is high.
  - A ball-ball report loads `pair_pend` with the two IDs. A later report in the same frame overwrites the earlier one.
- Snapshot: `startOfFrame` in IDLE copies the pending registers into working registers and clears the pending registers in that same cycle. An event that arrives in the snapshot cycle goes to the pending registers and is handled in the next frame.
- `startOfFrame` while `busy` is ignored. The frame counter does not advance on an ignored pulse.
- States:
  - IDLE: wait for `startOfFrame`.
  - WALL (1 cycle): for every ball, negate X if `wall_x` is set and negate Y if `wall_y` is set.
  - PAIR (1 cycle): swap the full (x,y) speed vectors of the two balls. The swap is skipped if the IDs are equal or either ID is >= NUM_BALLS.
  - FRIC (NUM_BALLS cycles, index counter 0..NUM_BALLS-1): process ball[idx]:
    - If `balls_in_game[idx]` is 0, both speeds are forced to 0.
    - Otherwise, on friction frames, each nonzero component moves 1 toward 0.
  - DONE (1 cycle): pulse `update_done`, then return to IDLE.
- Friction frame: the frame counter is 0 at snapshot time. The counter counts modulo `FRICTION_DIV` and increments on every accepted `startOfFrame`.
- Negation saturates: the most negative value (-2^(SPEED_W-1)) negates to +2^(SPEED_W-1)-1.
- Shot: `shot_valid && shot_ready` loads ball 0 speeds on the next edge. A shot presented while `busy` has no effect and must be held by the source. If ball 0 is pocketed, the shot is still loaded, then zeroed in the next FRIC pass.
- Reset asserted mid-sequence returns to IDLE with all state cleared, including pending events.

## Timing
- `startOfFrame` sampled at edge t:
  - WALL at t+1.
  - PAIR at t+2.
  - FRIC at t+3 .. t+2+NUM_BALLS.
  - `update_done` high during cycle t+3+NUM_BALLS.
- Latency is NUM_BALLS+3 cycles (6 cycles at the default NUM_BALLS=3).
- Speed outputs are registered. They change only during WALL, PAIR and FRIC, or on an accepted shot, and are stable from `update_done` until the next sequence.
- `busy` is high from t+1 through t+3+NUM_BALLS inclusive.

## Structure
- Shared package `billiard_pkg` holds:
  - `NUM_BALLS` and `SPEED_W` defaults.
  - `wall_code_t` enum: NONE, VERT, HORZ, CORNER.
  - `resp_state_t` enum: IDLE, WALL, PAIR, FRIC, DONE.
  - `speed_t` typedef.
- One sub-module, `speed_step`: combinational saturating negate plus the toward-zero decrement on a single `speed_t`. It is instantiated for the X and Y components.

## Test plan
- Ball 1 speed (5,-3); wall pulse on ball 1 with `collided_wall`=01; then `startOfFrame` -> after 6 cycles ball 1 = (-5,-3), `update_done` pulses once.
- Balls 0=(4,0) and 2=(-2,1); `Balls_col_ID`=(0,2) pulse -> after the frame, 0=(-2,1) and 2=(4,0). Same test with IDs (1,1) -> no change.
- `balls_in_game`=3'b101 with ball 1 at (7,7) -> ball 1 = (0,0) after the next frame.
- FRICTION_DIV=4, ball 0=(3,-3), no events -> after the first accepted frame (2,-2); unchanged for the next 3 frames; (1,-1) after frame 5.
- Wall event in the same cycle as `startOfFrame` -> no reflection this frame; reflection applied on the following frame. `startOfFrame` while busy -> ignored, still exactly one `update_done`.
- Ball 0 X = -1024 with a vertical wall event -> X = +1023. Also: shot (10,-6) with `shot_ready`=1 -> ball 0 = (10,-6) next cycle; `resetN`=0 mid-FRIC -> all speeds 0, `busy` 0.
